// File: rtl/wdt_service_ctrl_pkg.sv
// Shared definitions for the watchdog service controller.
//   KEY1/KEY2     : unlock-key values written by the CPU to request a kick
//   fsm_state_t   : escalation FSM encoding (legacy-compatible constants)
//   key_state_t   : key-sequence detector encoding
package wdt_service_ctrl_pkg;

    localparam logic [15:0] KEY1 = 16'h5555;
    localparam logic [15:0] KEY2 = 16'hAAAA;

    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t S_IDLE  = 2'd0;
    localparam fsm_state_t S_ARMED = 2'd1;
    localparam fsm_state_t S_WARN  = 2'd2;
    localparam fsm_state_t S_RESET = 2'd3;

    typedef logic key_state_t;
    localparam key_state_t K_IDLE = 1'b0;
    localparam key_state_t K_GOT1 = 1'b1;

endpackage

// File: rtl/wdt_service_ctrl_if.sv
// Signal bundle between the CPU/watchdog-core side and the service controller.
//   slave  : view of the controller (inputs: CPU writes, core status; outputs: kick, irq, ...)
//   master : view of whoever drives the controller (CPU model / core / bench)
interface wdt_service_ctrl_if;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        tmr_en;
    logic        to_flag;
    logic [31:0] tmr;
    logic [31:0] window;
    logic        irq_clr;
    logic        kick;
    logic        irq;
    logic        rst_req;
    logic        key_err;
    logic        win_err;
    logic [7:0]  tcnt;

    modport slave (
        input  wr_en, wr_data, tmr_en, to_flag, tmr, window, irq_clr,
        output kick, irq, rst_req, key_err, win_err, tcnt
    );

    modport master (
        output wr_en, wr_data, tmr_en, to_flag, tmr, window, irq_clr,
        input  kick, irq, rst_req, key_err, win_err, tcnt
    );
endinterface

// File: rtl/wdt_service_ctrl_key_seq.sv
// Two-write unlock-key detector for the watchdog service register.
//   clk, rst_n : clock, async active-low reset
//   wr_en      : 1-cycle CPU write strobe
//   wr_data    : CPU write data
//   clr        : synchronous abort (watchdog disabled), returns to K_IDLE
//   accept     : combinational, high in the cycle a valid KEY2 write completes the sequence
//   key_err    : registered 1-cycle pulse after a wrong value breaks the sequence
// The KEY1->KEY2 gap may be at most KEY_TMO cycles; a down-counter loaded on
// each KEY1 write expires the sequence silently when it reaches zero.
module wdt_key_seq
    import wdt_service_ctrl_pkg::*;
#(
    parameter int KEY_TMO = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic        clr,
    output logic        accept,
    output logic        key_err
);

    localparam int              TW       = $clog2(KEY_TMO);
    localparam logic [TW-1:0]   TMO_LOAD = TW'(KEY_TMO - 1);

    key_state_t      st_q, st_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic            key_err_q, key_err_d;

    always_comb begin
        st_d      = st_q;
        cnt_d     = cnt_q;
        key_err_d = 1'b0;
        accept    = 1'b0;
        if (clr) begin
            st_d = K_IDLE;
        end else if (st_q == K_IDLE) begin
            if (wr_en && wr_data == KEY1) begin
                st_d  = K_GOT1;
                cnt_d = TMO_LOAD;
            end
        end else begin
            if (wr_en) begin
                if (wr_data == KEY2) begin
                    accept = 1'b1;
                    st_d   = K_IDLE;
                end else if (wr_data == KEY1) begin
                    cnt_d = TMO_LOAD;
                end else begin
                    key_err_d = 1'b1;
                    st_d      = K_IDLE;
                end
            end else if (cnt_q == '0) begin
                // KEY_TMO idle cycles since KEY1: abandon without error
                st_d = K_IDLE;
            end else begin
                cnt_d = cnt_q - TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= K_IDLE;
            cnt_q     <= '0;
            key_err_q <= 1'b0;
        end else begin
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            key_err_q <= key_err_d;
        end
    end

    assign key_err = key_err_q;

endmodule

// File: rtl/wdt_service_ctrl.sv
// Watchdog service and escalation controller (CPU side of the kick/timeout link).
//   clk, rst_n : clock, async active-low reset
//   bus        : wdt_service_ctrl_if.slave
//                in : wr_en, wr_data, tmr_en, to_flag, tmr, window, irq_clr
//                out: kick (1-cycle reload), irq (sticky warning), rst_req,
//                     key_err, win_err, tcnt (saturating timeout count)
// Build option: WDT_WINDOW_EN enables the early-kick window check
// (KEY2 accepted while tmr > window -> no kick, win_err, escalate to RESET).
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | watchdog disabled, waiting for tmr_en
// S_ARMED | running, no outstanding timeout
// S_WARN  | one timeout seen, irq raised, a kick returns to S_ARMED
// S_RESET | rst_req asserted for RST_PULSE cycles, then back to S_ARMED
module wdt_service_ctrl
    import wdt_service_ctrl_pkg::*;
#(
    parameter int KEY_TMO   = 64,
    parameter int RST_PULSE = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    wdt_service_ctrl_if.slave  bus
);

    localparam int            RW       = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
    localparam logic [RW-1:0] RST_LOAD = RW'(RST_PULSE - 1);

    fsm_state_t    st_q, st_d;
    logic [RW-1:0] rc_q, rc_d;
    logic          irq_q, irq_d;
    logic          kick_q, kick_d;
    logic [7:0]    tcnt_q, tcnt_d;
    logic          flag_q, en_q;
    logic          accept, key_err, tmo_evt, early;

    wdt_key_seq #(.KEY_TMO(KEY_TMO)) u_key_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bus.wr_en),
        .wr_data (bus.wr_data),
        .clr     (~bus.tmr_en),
        .accept  (accept),
        .key_err (key_err)
    );

    // Edge only counts when the watchdog was running on both sides of it,
    // so a to_flag left high across a disable/enable is not a new timeout.
    assign tmo_evt = bus.to_flag & ~flag_q & bus.tmr_en & en_q;

`ifdef WDT_WINDOW_EN
    logic win_err_q;
    assign early = accept & bus.tmr_en & (st_q != S_RESET) & (bus.tmr > bus.window);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) win_err_q <= 1'b0;
        else        win_err_q <= early;
    end
    assign bus.win_err = win_err_q;
`else
    logic unused_win;
    assign unused_win  = ^{bus.tmr, bus.window};
    assign early       = 1'b0;
    assign bus.win_err = 1'b0;
`endif

    always_comb begin
        kick_d = accept & bus.tmr_en & (st_q != S_RESET) & ~early;
        tcnt_d = (tmo_evt && tcnt_q != 8'hFF) ? tcnt_q + 8'd1 : tcnt_q;
        st_d   = st_q;
        rc_d   = rc_q;
        irq_d  = irq_q;
        if (bus.irq_clr) irq_d = 1'b0;
        case (st_q)
            S_IDLE: begin
                if (bus.tmr_en) st_d = S_ARMED;
            end
            S_ARMED: begin
                if (early) begin
                    st_d = S_RESET;
                    rc_d = RST_LOAD;
                end else if (tmo_evt) begin
                    st_d  = S_WARN;
                    irq_d = 1'b1;
                end
            end
            S_WARN: begin
                // A timeout coinciding with the kick pulse still escalates.
                if (tmo_evt || early) begin
                    st_d = S_RESET;
                    rc_d = RST_LOAD;
                end else if (kick_q) begin
                    st_d  = S_ARMED;
                    irq_d = 1'b0;
                end
            end
            S_RESET: begin
                if (rc_q == '0) begin
                    st_d  = bus.tmr_en ? S_ARMED : S_IDLE;
                    irq_d = 1'b0;
                end else begin
                    rc_d = rc_q - RW'(1);
                end
            end
            default: st_d = S_IDLE;
        endcase
        // Disable aborts everything except a reset pulse already in flight.
        if (!bus.tmr_en) begin
            irq_d = 1'b0;
            if (st_q != S_RESET) st_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= S_IDLE;
            rc_q   <= '0;
            irq_q  <= 1'b0;
            kick_q <= 1'b0;
            tcnt_q <= 8'h00;
            flag_q <= 1'b0;
            en_q   <= 1'b0;
        end else begin
            st_q   <= st_d;
            rc_q   <= rc_d;
            irq_q  <= irq_d;
            kick_q <= kick_d;
            tcnt_q <= tcnt_d;
            flag_q <= bus.to_flag;
            en_q   <= bus.tmr_en;
        end
    end

    assign bus.kick    = kick_q;
    assign bus.irq     = irq_q;
    assign bus.rst_req = (st_q == S_RESET);
    assign bus.key_err = key_err;
    assign bus.tcnt    = tcnt_q;

endmodule

// File: tb/tb_wdt_service_ctrl.sv
module tb_wdt_service_ctrl;

    localparam int          KEY_TMO   = 64;
    localparam int          RST_PULSE = 16;
    localparam logic [15:0] K1 = 16'h5555;
    localparam logic [15:0] K2 = 16'hAAAA;
`ifdef WDT_WINDOW_EN
    localparam bit WIN_EN = 1'b1;
`else
    localparam bit WIN_EN = 1'b0;
`endif

    localparam int P_IDLE = 0, P_ARMED = 1, P_WARN = 2, P_RESET = 3;

    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    wdt_service_ctrl_if bus();

    wdt_service_ctrl #(.KEY_TMO(KEY_TMO), .RST_PULSE(RST_PULSE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural reference
    int cyc = 0;
    bit m_got1;
    int m_key1_cyc;
    bit m_prev_flag, m_prev_en;
    int m_phase;
    int m_rst_left;
    bit m_irq;
    int m_tcnt;
    bit m_kick, m_key_err, m_win_err;

    task automatic model_step();
        bit valid, accept, kerr, early, ev, kick_now, kick_next;
        kick_now = m_kick;
        valid    = m_got1 && ((cyc - m_key1_cyc) <= KEY_TMO);
        accept   = 1'b0;
        kerr     = 1'b0;
        if (!bus.tmr_en) begin
            m_got1 = 1'b0;
        end else if (bus.wr_en) begin
            if (valid) begin
                if (bus.wr_data == K2) begin
                    accept = 1'b1;
                    m_got1 = 1'b0;
                end else if (bus.wr_data == K1) begin
                    m_key1_cyc = cyc;
                end else begin
                    kerr   = 1'b1;
                    m_got1 = 1'b0;
                end
            end else if (bus.wr_data == K1) begin
                m_got1     = 1'b1;
                m_key1_cyc = cyc;
            end else begin
                m_got1 = 1'b0;
            end
        end
        early     = WIN_EN && accept && (m_phase != P_RESET) && (bus.tmr > bus.window);
        kick_next = accept && (m_phase != P_RESET) && !early;
        ev        = bus.tmr_en && m_prev_en && bus.to_flag && !m_prev_flag;
        if (ev && m_tcnt < 255) m_tcnt++;
        if (bus.irq_clr) m_irq = 1'b0;
        case (m_phase)
            P_IDLE:  if (bus.tmr_en) m_phase = P_ARMED;
            P_ARMED: begin
                if (early) begin
                    m_phase = P_RESET; m_rst_left = RST_PULSE;
                end else if (ev) begin
                    m_phase = P_WARN; m_irq = 1'b1;
                end
            end
            P_WARN: begin
                if (ev || early) begin
                    m_phase = P_RESET; m_rst_left = RST_PULSE;
                end else if (kick_now) begin
                    m_phase = P_ARMED; m_irq = 1'b0;
                end
            end
            default: begin
                m_rst_left--;
                if (m_rst_left == 0) begin
                    m_phase = bus.tmr_en ? P_ARMED : P_IDLE;
                    m_irq   = 1'b0;
                end
            end
        endcase
        if (!bus.tmr_en) begin
            m_irq = 1'b0;
            if (m_phase != P_RESET) m_phase = P_IDLE;
        end
        m_kick      = kick_next;
        m_key_err   = kerr;
        m_win_err   = early;
        m_prev_flag = bus.to_flag;
        m_prev_en   = bus.tmr_en;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic write_key(input logic [15:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        cycle();
        bus.wr_en   = 1'b0;
        bus.wr_data = 16'h0;
    endtask

    task automatic test_reset();
        bus.wr_en = 0; bus.wr_data = 0; bus.tmr_en = 0; bus.to_flag = 0;
        bus.tmr = 0; bus.window = 0; bus.irq_clr = 0;
        m_got1 = 0; m_key1_cyc = 0; m_prev_flag = 0; m_prev_en = 0;
        m_phase = P_IDLE; m_rst_left = 0; m_irq = 0; m_tcnt = 0;
        m_kick = 0; m_key_err = 0; m_win_err = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.kick !== 1'b0)    begin $display("FAIL reset_kick got %b want 0", bus.kick); n_bad++; end
        n_cmp++; if (bus.irq !== 1'b0)     begin $display("FAIL reset_irq got %b want 0", bus.irq); n_bad++; end
        n_cmp++; if (bus.rst_req !== 1'b0) begin $display("FAIL reset_rst_req got %b want 0", bus.rst_req); n_bad++; end
        n_cmp++; if (bus.key_err !== 1'b0) begin $display("FAIL reset_key_err got %b want 0", bus.key_err); n_bad++; end
        n_cmp++; if (bus.win_err !== 1'b0) begin $display("FAIL reset_win_err got %b want 0", bus.win_err); n_bad++; end
        n_cmp++; if (bus.tcnt !== 8'h00)   begin $display("FAIL reset_tcnt got %h want 00", bus.tcnt); n_bad++; end
        rst_n = 1'b1;
    endtask

    task automatic test_kick();
        bus.tmr_en = 1'b1;
        cycle(); cycle();
        write_key(K1);
        write_key(K2);
        n_cmp++; if (bus.kick !== 1'b1) begin $display("FAIL kick_pulse got %b want 1", bus.kick); n_bad++; end
        cycle();
        n_cmp++; if (bus.kick !== 1'b0) begin $display("FAIL kick_one_cycle got %b want 0", bus.kick); n_bad++; end
        write_key(K1);
        bus.tmr_en = 1'b0;
        write_key(K2);
        n_cmp++; if (bus.kick !== 1'b0) begin $display("FAIL kick_disabled got %b want 0", bus.kick); n_bad++; end
        bus.tmr_en = 1'b1;
        cycle(); cycle();
    endtask

    task automatic test_key_err();
        write_key(K1);
        write_key(16'h1234);
        n_cmp++; if (bus.key_err !== 1'b1) begin $display("FAIL key_err_pulse got %b want 1", bus.key_err); n_bad++; end
        n_cmp++; if (bus.kick !== 1'b0)    begin $display("FAIL key_err_no_kick got %b want 0", bus.kick); n_bad++; end
        cycle();
        n_cmp++; if (bus.key_err !== 1'b0) begin $display("FAIL key_err_one_cycle got %b want 0", bus.key_err); n_bad++; end
        write_key(K1);
        repeat (KEY_TMO) cycle();
        write_key(K2);
        n_cmp++; if (bus.kick !== 1'b0)    begin $display("FAIL key_tmo_no_kick got %b want 0", bus.kick); n_bad++; end
        n_cmp++; if (bus.key_err !== 1'b0) begin $display("FAIL key_tmo_no_err got %b want 0", bus.key_err); n_bad++; end
        write_key(K1);
        repeat (KEY_TMO - 1) cycle();
        write_key(K2);
        n_cmp++; if (bus.kick !== 1'b1)    begin $display("FAIL key_tmo_edge_kick got %b want 1", bus.kick); n_bad++; end
        cycle();
    endtask

    task automatic test_escalation();
        int n;
        bus.to_flag = 1'b1; cycle();
        n_cmp++; if (bus.irq !== 1'b1)   begin $display("FAIL esc_irq got %b want 1", bus.irq); n_bad++; end
        n_cmp++; if (bus.tcnt !== 8'd1)  begin $display("FAIL esc_tcnt1 got %0d want 1", bus.tcnt); n_bad++; end
        bus.to_flag = 1'b0; cycle();
        bus.to_flag = 1'b1; cycle();
        bus.to_flag = 1'b0;
        n_cmp++; if (bus.rst_req !== 1'b1) begin $display("FAIL esc_rst_req got %b want 1", bus.rst_req); n_bad++; end
        n = 1;
        for (int i = 0; i < RST_PULSE + 8; i++) begin
            cycle();
            if (bus.rst_req === 1'b1) n++; else break;
        end
        n_cmp++; if (n != RST_PULSE)    begin $display("FAIL esc_rst_len got %0d want %0d", n, RST_PULSE); n_bad++; end
        n_cmp++; if (bus.irq !== 1'b0)  begin $display("FAIL esc_irq_cleared got %b want 0", bus.irq); n_bad++; end
        n_cmp++; if (bus.tcnt !== 8'd2) begin $display("FAIL esc_tcnt2 got %0d want 2", bus.tcnt); n_bad++; end
    endtask

    task automatic test_warn_kick();
        bus.to_flag = 1'b1; cycle(); bus.to_flag = 1'b0;
        n_cmp++; if (bus.irq !== 1'b1) begin $display("FAIL warn_irq got %b want 1", bus.irq); n_bad++; end
        write_key(K1);
        write_key(K2);
        cycle();
        n_cmp++; if (bus.irq !== 1'b0) begin $display("FAIL warn_kick_clears got %b want 0", bus.irq); n_bad++; end
        bus.to_flag = 1'b1; cycle(); bus.to_flag = 1'b0;
        n_cmp++; if (bus.irq !== 1'b1)     begin $display("FAIL rearm_irq got %b want 1", bus.irq); n_bad++; end
        n_cmp++; if (bus.rst_req !== 1'b0) begin $display("FAIL rearm_no_rst got %b want 0", bus.rst_req); n_bad++; end
    endtask

    task automatic test_same_cycle();
        int n;
        write_key(K1);
        write_key(K2);
        n_cmp++; if (bus.kick !== 1'b1) begin $display("FAIL same_kick got %b want 1", bus.kick); n_bad++; end
        bus.to_flag = 1'b1; cycle(); bus.to_flag = 1'b0;
        n_cmp++; if (bus.rst_req !== 1'b1) begin $display("FAIL same_evt_rst got %b want 1", bus.rst_req); n_bad++; end
        n = 1;
        for (int i = 0; i < RST_PULSE + 8; i++) begin
            if (i == 4) bus.tmr_en = 1'b0;
            cycle();
            if (bus.rst_req === 1'b1) n++; else break;
        end
        n_cmp++; if (n != RST_PULSE)    begin $display("FAIL en_drop_rst_len got %0d want %0d", n, RST_PULSE); n_bad++; end
        n_cmp++; if (bus.irq !== 1'b0)  begin $display("FAIL en_drop_irq got %b want 0", bus.irq); n_bad++; end
        n_cmp++; if (bus.tcnt !== 8'd5) begin $display("FAIL same_tcnt got %0d want 5", bus.tcnt); n_bad++; end
        bus.tmr_en = 1'b1;
        cycle(); cycle();
    endtask

    task automatic test_irq_clr();
        bus.to_flag = 1'b1; bus.irq_clr = 1'b1; cycle();
        bus.to_flag = 1'b0; bus.irq_clr = 1'b0;
        n_cmp++; if (bus.irq !== 1'b1) begin $display("FAIL clr_set_wins got %b want 1", bus.irq); n_bad++; end
        bus.irq_clr = 1'b1; cycle(); bus.irq_clr = 1'b0;
        n_cmp++; if (bus.irq !== 1'b0) begin $display("FAIL clr_irq got %b want 0", bus.irq); n_bad++; end
        bus.to_flag = 1'b1; cycle(); bus.to_flag = 1'b0;
        n_cmp++; if (bus.rst_req !== 1'b1) begin $display("FAIL clr_state_kept got %b want 1", bus.rst_req); n_bad++; end
        for (int i = 0; i < RST_PULSE + 8; i++) begin
            if (bus.rst_req !== 1'b1) break;
            cycle();
        end
        n_cmp++; if (bus.rst_req !== 1'b0) begin $display("FAIL clr_rst_done got %b want 0", bus.rst_req); n_bad++; end
    endtask

    task automatic test_window();
        logic exp_kick, exp_we, exp_rr;
`ifdef WDT_WINDOW_EN
        exp_kick = 1'b0; exp_we = 1'b1; exp_rr = 1'b1;
`else
        exp_kick = 1'b1; exp_we = 1'b0; exp_rr = 1'b0;
`endif
        bus.window = 32'd100;
        bus.tmr    = 32'd500;
        write_key(K1);
        write_key(K2);
        n_cmp++; if (bus.kick !== exp_kick)  begin $display("FAIL win_early_kick got %b want %b", bus.kick, exp_kick); n_bad++; end
        n_cmp++; if (bus.win_err !== exp_we) begin $display("FAIL win_early_err got %b want %b", bus.win_err, exp_we); n_bad++; end
        n_cmp++; if (bus.rst_req !== exp_rr) begin $display("FAIL win_early_rst got %b want %b", bus.rst_req, exp_rr); n_bad++; end
        for (int i = 0; i < RST_PULSE + 8; i++) begin
            if (bus.rst_req !== 1'b1) break;
            cycle();
        end
        bus.tmr = 32'd50;
        write_key(K1);
        write_key(K2);
        n_cmp++; if (bus.kick !== 1'b1)    begin $display("FAIL win_ok_kick got %b want 1", bus.kick); n_bad++; end
        n_cmp++; if (bus.win_err !== 1'b0) begin $display("FAIL win_ok_err got %b want 0", bus.win_err); n_bad++; end
        cycle();
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            bus.wr_en = (r < 33);
            r = $urandom_range(0, 9);
            bus.wr_data = (r < 4) ? K1 : (r < 8) ? K2 : 16'($urandom);
            if ($urandom_range(0, 7) == 0) bus.to_flag = ~bus.to_flag;
            if (bus.tmr_en) begin
                if ($urandom_range(0, 99) == 0) bus.tmr_en = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                bus.tmr_en = 1'b1;
            end
            bus.irq_clr = ($urandom_range(0, 19) == 0);
            bus.tmr     = 32'($urandom_range(0, 200));
            cycle();
            n_cmp++; if (bus.kick !== m_kick)       begin $display("FAIL rnd_kick cyc=%0d got %b want %b", cyc, bus.kick, m_kick); n_bad++; end
            n_cmp++; if (bus.irq !== m_irq)         begin $display("FAIL rnd_irq cyc=%0d got %b want %b", cyc, bus.irq, m_irq); n_bad++; end
            n_cmp++; if (bus.rst_req !== (m_phase == P_RESET)) begin $display("FAIL rnd_rst_req cyc=%0d got %b want %b", cyc, bus.rst_req, m_phase == P_RESET); n_bad++; end
            n_cmp++; if (bus.key_err !== m_key_err) begin $display("FAIL rnd_key_err cyc=%0d got %b want %b", cyc, bus.key_err, m_key_err); n_bad++; end
            n_cmp++; if (bus.win_err !== m_win_err) begin $display("FAIL rnd_win_err cyc=%0d got %b want %b", cyc, bus.win_err, m_win_err); n_bad++; end
            n_cmp++; if (bus.tcnt !== 8'(m_tcnt))   begin $display("FAIL rnd_tcnt cyc=%0d got %0d want %0d", cyc, bus.tcnt, m_tcnt); n_bad++; end
        end
        bus.wr_en = 1'b0; bus.irq_clr = 1'b0;
    endtask

    task automatic test_saturation();
        bus.tmr_en = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            bus.to_flag = ((i / 2) % 2) == 1;
            cycle();
        end
        n_cmp++; if (bus.tcnt !== 8'hFF)      begin $display("FAIL tcnt_saturate got %h want ff", bus.tcnt); n_bad++; end
        n_cmp++; if (bus.tcnt !== 8'(m_tcnt)) begin $display("FAIL tcnt_model got %0d want %0d", bus.tcnt, m_tcnt); n_bad++; end
    endtask

    initial begin
        test_reset();
        test_kick();
        test_key_err();
        test_escalation();
        test_warn_kick();
        test_same_cycle();
        test_irq_clr();
        test_window();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL sim_timeout got no finish want finish before time limit");
        $fatal(1, "simulation time limit reached");
    end

endmodule
